// File: rtl/exc_ctrl.sv
// exc_ctrl -- MEM-stage exception arbiter feeding cp0.
//
// Samples the retiring instruction's exception flags and the pending
// interrupts. It picks one event by priority (int > RI > ov > syscall > eret)
// and presents it to cp0 as a one-cycle pulse. It also drives the pipeline
// flush and a PC redirect to the handler vector, or to EPC on ERET.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   mem_valid_i           retiring instruction valid in MEM
//   mem_pc_i              PC of the retiring instruction
//   mem_in_delayslot_i    instruction sits in a branch delay slot
//   mem_syscall_i/ri_i/ov_i/eret_i   exception / ERET flags
//   cp0_status_i          Status (bit0 IE, bit1 EXL, bits15:8 IM)
//   cp0_cause_i           Cause (bits15:8 IP)
//   cp0_epc_i             EPC, the ERET return target
//   except_o              event code pulse (1 int, 8 sys, a RI, c ov, e eret)
//   exc_pc_o              cur_inst_addr pulse to cp0
//   exc_delayslot_o       in_delayslot pulse to cp0
//   flush_o               flush IF..MEM, held FLUSH_CYCLES cycles per event
//   redirect_o            one-cycle strobe: load new_pc_o into PC
//   new_pc_o              redirect target, held until the next event
//   exc_count_o           taken events, saturating at 16'hFFFF
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic        mem_syscall_i,
  input  logic        mem_ri_i,
  input  logic        mem_ov_i,
  input  logic        mem_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] except_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_delayslot_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] new_pc_o,
  output logic [15:0] exc_count_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [31:0] CODE_NONE = 32'h0000_0000;
  localparam logic [31:0] CODE_INT  = 32'h0000_0001;
  localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
  localparam logic [31:0] CODE_RI   = 32'h0000_000a;
  localparam logic [31:0] CODE_OV   = 32'h0000_000c;
  localparam logic [31:0] CODE_ERET = 32'h0000_000e;
  localparam logic [3:0]  FLUSH_LAST = FLUSH_CYCLES[3:0];

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  flush_cnt_r;
  logic [3:0]  flush_cnt_next_s;
  logic        flush_next_s;
  logic        int_pending_s;
  logic        take_s;
  logic        take_eret_s;
  logic [31:0] code_s;

  assign int_pending_s = ((cp0_cause_i[15:8] & cp0_status_i[15:8]) != 8'h00) &&
                         cp0_status_i[0] && !cp0_status_i[1];

  // Priority pick of the event; only a valid instruction in IDLE can raise one.
  always_comb begin
    code_s      = CODE_NONE;
    take_s      = 1'b0;
    take_eret_s = 1'b0;
    if ((state_r == ST_IDLE) && mem_valid_i) begin
      if (int_pending_s) begin
        code_s = CODE_INT;
        take_s = 1'b1;
      end else if (mem_ri_i) begin
        code_s = CODE_RI;
        take_s = 1'b1;
      end else if (mem_ov_i) begin
        code_s = CODE_OV;
        take_s = 1'b1;
      end else if (mem_syscall_i) begin
        code_s = CODE_SYS;
        take_s = 1'b1;
      end else if (mem_eret_i) begin
        code_s      = CODE_ERET;
        take_s      = 1'b1;
        take_eret_s = 1'b1;
      end else begin
        code_s = CODE_NONE;
      end
    end else begin
      code_s = CODE_NONE;
    end
  end

  // Next state and flush counter: the counter runs 1..FLUSH_CYCLES while flushing.
  always_comb begin
    state_next_s     = state_r;
    flush_cnt_next_s = flush_cnt_r;
    flush_next_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_next_s     = ST_FLUSH;
          flush_cnt_next_s = 4'd1;
          flush_next_s     = 1'b1;
        end else begin
          state_next_s     = ST_IDLE;
          flush_cnt_next_s = 4'd0;
          flush_next_s     = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r >= FLUSH_LAST) begin
          state_next_s     = ST_IDLE;
          flush_cnt_next_s = 4'd0;
          flush_next_s     = 1'b0;
        end else begin
          state_next_s     = ST_FLUSH;
          flush_cnt_next_s = flush_cnt_r + 4'd1;
          flush_next_s     = 1'b1;
        end
      end
      default: begin
        state_next_s     = ST_IDLE;
        flush_cnt_next_s = 4'd0;
        flush_next_s     = 1'b0;
      end
    endcase
  end

  // State register and flush counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_next_s;
      flush_cnt_r <= flush_cnt_next_s;
    end
  end

  // Registered outputs: cp0 fields and redirect pulse for one cycle only, so cp0 applies each event once.
  always_ff @(posedge clk) begin
    if (rst) begin
      except_o        <= 32'h0000_0000;
      exc_pc_o        <= 32'h0000_0000;
      exc_delayslot_o <= 1'b0;
      redirect_o      <= 1'b0;
      flush_o         <= 1'b0;
      new_pc_o        <= 32'h0000_0000;
    end else begin
      except_o        <= code_s;
      exc_pc_o        <= take_s ? mem_pc_i : 32'h0000_0000;
      exc_delayslot_o <= take_s & mem_in_delayslot_i;
      redirect_o      <= take_s;
      flush_o         <= flush_next_s;
      if (take_s) begin
        new_pc_o <= take_eret_s ? cp0_epc_i : EXC_VECTOR;
      end
    end
  end

  // Saturating count of taken events.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count_o <= 16'h0000;
    end else if (take_s && (exc_count_o != 16'hFFFF)) begin
      exc_count_o <= exc_count_o + 16'h0001;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic        mem_syscall_i;
  logic        mem_ri_i;
  logic        mem_ov_i;
  logic        mem_eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] except_o;
  logic [31:0] exc_pc_o;
  logic        exc_delayslot_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] new_pc_o;
  logic [15:0] exc_count_o;

  int vectors;
  int miscompares;

  exc_ctrl #(
    .EXC_VECTOR  (32'h0000_0020),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_valid_i       (mem_valid_i),
    .mem_pc_i          (mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i),
    .mem_syscall_i     (mem_syscall_i),
    .mem_ri_i          (mem_ri_i),
    .mem_ov_i          (mem_ov_i),
    .mem_eret_i        (mem_eret_i),
    .cp0_status_i      (cp0_status_i),
    .cp0_cause_i       (cp0_cause_i),
    .cp0_epc_i         (cp0_epc_i),
    .except_o          (except_o),
    .exc_pc_o          (exc_pc_o),
    .exc_delayslot_o   (exc_delayslot_o),
    .flush_o           (flush_o),
    .redirect_o        (redirect_o),
    .new_pc_o          (new_pc_o),
    .exc_count_o       (exc_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock edge; the bench then samples and drives 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid_i        = 1'b0;
    mem_pc_i           = 32'h0000_0000;
    mem_in_delayslot_i = 1'b0;
    mem_syscall_i      = 1'b0;
    mem_ri_i           = 1'b0;
    mem_ov_i           = 1'b0;
    mem_eret_i         = 1'b0;
    cp0_status_i       = 32'h0000_0000;
    cp0_cause_i        = 32'h0000_0000;
    cp0_epc_i          = 32'h0000_0000;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear_inputs();

    // Reset held three cycles with a valid syscall present: nothing may leak out.
    rst           = 1'b1;
    mem_valid_i   = 1'b1;
    mem_syscall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_except",   except_o,           32'h0000_0000);
      check("rst_flush",    {31'd0, flush_o},    32'h0000_0000);
      check("rst_redirect", {31'd0, redirect_o}, 32'h0000_0000);
      check("rst_count",    {16'd0, exc_count_o}, 32'h0000_0000);
    end
    check("rst_newpc", new_pc_o, 32'h0000_0000);
    check("rst_excpc", exc_pc_o, 32'h0000_0000);
    rst = 1'b0;
    clear_inputs();
    tick();

    // Syscall: pulse next cycle, flush for two cycles.
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h0000_0100;
    mem_syscall_i = 1'b1;
    tick();
    check("sys_except",   except_o,            32'h0000_0008);
    check("sys_excpc",    exc_pc_o,            32'h0000_0100);
    check("sys_newpc",    new_pc_o,            32'h0000_0020);
    check("sys_redirect", {31'd0, redirect_o}, 32'h0000_0001);
    check("sys_flush1",   {31'd0, flush_o},    32'h0000_0001);
    check("sys_count",    {16'd0, exc_count_o}, 32'h0000_0001);
    clear_inputs();
    tick();
    check("sys_except_clr",   except_o,            32'h0000_0000);
    check("sys_redirect_clr", {31'd0, redirect_o}, 32'h0000_0000);
    check("sys_excpc_clr",    exc_pc_o,            32'h0000_0000);
    check("sys_flush2",       {31'd0, flush_o},    32'h0000_0001);
    check("sys_newpc_hold",   new_pc_o,            32'h0000_0020);
    tick();
    check("sys_flush_end", {31'd0, flush_o}, 32'h0000_0000);

    // Interrupt beats RI, ov and syscall.
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h0000_0200;
    mem_ri_i      = 1'b1;
    mem_ov_i      = 1'b1;
    mem_syscall_i = 1'b1;
    cp0_status_i  = 32'h0000_0401;
    cp0_cause_i   = 32'h0000_0400;
    tick();
    check("prio_int",       except_o, 32'h0000_0001);
    check("prio_int_count", {16'd0, exc_count_o}, 32'h0000_0002);
    clear_inputs();
    tick();
    tick();

    // EXL set masks the interrupt: RI wins.
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h0000_0204;
    mem_ri_i      = 1'b1;
    mem_ov_i      = 1'b1;
    mem_syscall_i = 1'b1;
    cp0_status_i  = 32'h0000_0403;
    cp0_cause_i   = 32'h0000_0400;
    tick();
    check("prio_ri", except_o, 32'h0000_000a);
    clear_inputs();
    tick();
    tick();

    // Overflow beats syscall.
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h0000_0208;
    mem_ov_i      = 1'b1;
    mem_syscall_i = 1'b1;
    tick();
    check("prio_ov",       except_o, 32'h0000_000c);
    check("prio_ov_count", {16'd0, exc_count_o}, 32'h0000_0004);
    clear_inputs();
    tick();
    tick();

    // Invalid instruction: flags and a pending interrupt are ignored.
    mem_syscall_i = 1'b1;
    cp0_status_i  = 32'h0000_0401;
    cp0_cause_i   = 32'h0000_0400;
    tick();
    check("invalid_except", except_o,            32'h0000_0000);
    check("invalid_flush",  {31'd0, flush_o},    32'h0000_0000);
    check("invalid_count",  {16'd0, exc_count_o}, 32'h0000_0004);
    clear_inputs();

    // ERET redirects to EPC and reports the delay slot.
    mem_valid_i        = 1'b1;
    mem_pc_i           = 32'h0000_0300;
    mem_eret_i         = 1'b1;
    mem_in_delayslot_i = 1'b1;
    cp0_epc_i          = 32'h0000_0BC0;
    tick();
    check("eret_except", except_o,                 32'h0000_000e);
    check("eret_newpc",  new_pc_o,                 32'h0000_0BC0);
    check("eret_ds",     {31'd0, exc_delayslot_o}, 32'h0000_0001);
    check("eret_excpc",  exc_pc_o,                 32'h0000_0300);
    clear_inputs();
    tick();
    check("eret_ds_clr", {31'd0, exc_delayslot_o}, 32'h0000_0000);
    tick();

    // Second syscall on the first FLUSH cycle is dropped.
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h0000_0400;
    mem_syscall_i = 1'b1;
    tick();
    check("blk_first",  except_o, 32'h0000_0008);
    check("blk_count1", {16'd0, exc_count_o}, 32'h0000_0006);
    mem_pc_i = 32'h0000_0404;
    tick();
    check("blk_except",   except_o,            32'h0000_0000);
    check("blk_redirect", {31'd0, redirect_o}, 32'h0000_0000);
    check("blk_flush",    {31'd0, flush_o},    32'h0000_0001);
    clear_inputs();
    tick();
    check("blk_flush_end", {31'd0, flush_o}, 32'h0000_0000);
    tick();
    check("blk_count2", {16'd0, exc_count_o}, 32'h0000_0006);
    check("blk_none",   except_o,             32'h0000_0000);

    // Reset asserted mid-FLUSH.
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h0000_0500;
    mem_syscall_i = 1'b1;
    tick();
    check("mid_flush_on", {31'd0, flush_o}, 32'h0000_0001);
    clear_inputs();
    rst = 1'b1;
    tick();
    check("mid_flush_off", {31'd0, flush_o},    32'h0000_0000);
    check("mid_redirect",  {31'd0, redirect_o}, 32'h0000_0000);
    check("mid_count",     {16'd0, exc_count_o}, 32'h0000_0000);
    rst = 1'b0;
    tick();

    // Back in IDLE after reset: a syscall is taken at once.
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h0000_0600;
    mem_syscall_i = 1'b1;
    tick();
    check("post_rst_except", except_o, 32'h0000_0008);
    check("post_rst_count",  {16'd0, exc_count_o}, 32'h0000_0001);
    clear_inputs();
    tick();
    tick();

    // Saturation: preload the counter near the top, then run three events.
    force dut.exc_count_o = 16'hFFFD;
    #1;
    release dut.exc_count_o;
    for (int i = 0; i < 3; i++) begin
      mem_valid_i   = 1'b1;
      mem_pc_i      = 32'h0000_0700;
      mem_syscall_i = 1'b1;
      tick();
      clear_inputs();
      case (i)
        0:       check("sat_fffe", {16'd0, exc_count_o}, 32'h0000_FFFE);
        1:       check("sat_ffff", {16'd0, exc_count_o}, 32'h0000_FFFF);
        default: check("sat_hold", {16'd0, exc_count_o}, 32'h0000_FFFF);
      endcase
      tick();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
